// File: rtl/wreg_pkg.sv
// Shared encodings for the register-bank write port: destination codes and the
// write scheduler state encoding.
package wreg_pkg;

    localparam logic [1:0] WR_RT = 2'b00;
    localparam logic [1:0] WR_SP = 2'b01;
    localparam logic [1:0] WR_RA = 2'b10;
    localparam logic [1:0] WR_RD = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SLOT1 = 2'b01,
        SLOT2 = 2'b10
    } wsched_state_e;

endpackage

// File: rtl/wreg_write_sched.sv
// Serialises the one or two register writes of a write-back request (primary
// destination plus optional $sp update) onto the single register-bank write port.
module wreg_write_sched
    import wreg_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int SP_REG = 29,
    parameter int RA_REG = 31
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_dst,
    input  logic [4:0]        req_rt,
    input  logic [4:0]        req_rd,
    input  logic [DATA_W-1:0] req_prim_data,
    input  logic              req_sp_upd,
    input  logic              req_sp_first,
    input  logic [DATA_W-1:0] req_sp_data,
    output logic              reg_wr,
    output logic [1:0]        wreg_sel,
    output logic [4:0]        wreg_addr,
    output logic [DATA_W-1:0] wreg_data,
    output logic              done,
    output logic              err
);

    function automatic logic [4:0] resolve_addr(input logic [1:0] dst,
                                                input logic [4:0] rt,
                                                input logic [4:0] rd);
        logic [4:0] a;
        case (dst)
            WR_RT:   a = rt;
            WR_SP:   a = 5'(SP_REG);
            WR_RA:   a = 5'(RA_REG);
            default: a = rd;
        endcase
        return a;
    endfunction

    wsched_state_e state_q, state_d;

    logic              reg_wr_q, reg_wr_d;
    logic [1:0]        wreg_sel_q, wreg_sel_d;
    logic [4:0]        wreg_addr_q, wreg_addr_d;
    logic [DATA_W-1:0] wreg_data_q, wreg_data_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    // Latched request payload; only the second slot ever reads it back.
    logic              two_q, two_d;
    logic              sp_first_q, sp_first_d;
    logic [1:0]        dst_q, dst_d;
    logic [4:0]        rt_q, rt_d;
    logic [4:0]        rd_q, rd_d;
    logic [DATA_W-1:0] prim_q, prim_d;
    logic [DATA_W-1:0] sp_data_q, sp_data_d;

    logic accept;
    logic conflict;
    logic last_slot;
    logic [4:0] addr_tmp;

    assign last_slot = (state_q == SLOT2) || (state_q == SLOT1 && !two_q);
    assign req_ready = (state_q == IDLE) || last_slot;
    assign accept    = req_valid && req_ready;
    // A primary $sp write plus an $sp update would hit $29 twice; keep the primary only.
    assign conflict  = (req_dst == WR_SP) && req_sp_upd;

    always_comb begin
        state_d     = IDLE;
        reg_wr_d    = 1'b0;
        wreg_sel_d  = wreg_sel_q;
        wreg_addr_d = wreg_addr_q;
        wreg_data_d = wreg_data_q;
        done_d      = 1'b0;
        err_d       = err_q;
        two_d       = two_q;
        sp_first_d  = sp_first_q;
        dst_d       = dst_q;
        rt_d        = rt_q;
        rd_d        = rd_q;
        prim_d      = prim_q;
        sp_data_d   = sp_data_q;
        addr_tmp    = 5'd0;

        if (accept) begin
            state_d    = SLOT1;
            two_d      = req_sp_upd && !conflict;
            sp_first_d = req_sp_first;
            dst_d      = req_dst;
            rt_d       = req_rt;
            rd_d       = req_rd;
            prim_d     = req_prim_data;
            sp_data_d  = req_sp_data;
            err_d      = err_q || conflict;
            done_d     = !(req_sp_upd && !conflict);
            if (req_sp_upd && !conflict && req_sp_first) begin
                wreg_sel_d  = WR_SP;
                addr_tmp    = 5'(SP_REG);
                wreg_data_d = req_sp_data;
            end else begin
                wreg_sel_d  = req_dst;
                addr_tmp    = resolve_addr(req_dst, req_rt, req_rd);
                wreg_data_d = req_prim_data;
            end
            wreg_addr_d = addr_tmp;
            reg_wr_d    = (addr_tmp != 5'd0);
        end else if (state_q == SLOT1 && two_q) begin
            state_d = SLOT2;
            done_d  = 1'b1;
            if (sp_first_q) begin
                wreg_sel_d  = dst_q;
                addr_tmp    = resolve_addr(dst_q, rt_q, rd_q);
                wreg_data_d = prim_q;
            end else begin
                wreg_sel_d  = WR_SP;
                addr_tmp    = 5'(SP_REG);
                wreg_data_d = sp_data_q;
            end
            wreg_addr_d = addr_tmp;
            reg_wr_d    = (addr_tmp != 5'd0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            reg_wr_q    <= 1'b0;
            wreg_sel_q  <= 2'b00;
            wreg_addr_q <= 5'd0;
            wreg_data_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            two_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            reg_wr_q    <= reg_wr_d;
            wreg_sel_q  <= wreg_sel_d;
            wreg_addr_q <= wreg_addr_d;
            wreg_data_q <= wreg_data_d;
            done_q      <= done_d;
            err_q       <= err_d;
            two_q       <= two_d;
        end
    end

    always_ff @(posedge clk) begin
        sp_first_q <= sp_first_d;
        dst_q      <= dst_d;
        rt_q       <= rt_d;
        rd_q       <= rd_d;
        prim_q     <= prim_d;
        sp_data_q  <= sp_data_d;
    end

    assign reg_wr    = reg_wr_q;
    assign wreg_sel  = wreg_sel_q;
    assign wreg_addr = wreg_addr_q;
    assign wreg_data = wreg_data_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
